// File: rtl/lift_pkg.sv
// Shared definitions for the lift door sequencing stage: state encoding,
// direction codes and default dwell lengths.
package lift_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED    = 2'd0,
    ST_OPENING   = 2'd1,
    ST_OPEN_HOLD = 2'd2,
    ST_CLOSING   = 2'd3
  } door_state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int DEF_OPEN_CYCLES  = 50;
  localparam int DEF_HOLD_CYCLES  = 200;
  localparam int DEF_CLOSE_CYCLES = 50;
  localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/lift_dwell_timer.sv
// Loadable down-counter used for the door dwell phases; done flags count==0.
module lift_dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  // Load wins over decrement; the counter parks at zero rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/lift_door_controller.sv
// Door open/hold/close sequencer with dwell timing, request-clear pulses and
// motor interlock (motor allowed only while the door is fully closed).
module lift_door_controller
  import lift_pkg::*;
#(
  parameter int N_FLOORS     = 8,
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] i_flr_pos,
  input  logic                i_motion,
  input  logic                i_direction,
  input  logic                i_has_rqst_at_stopped_flr,
  input  logic                i_door_obstruct,
  input  logic                i_open_btn,
  input  logic                i_close_btn,
  output logic                o_motion_enable,
  output logic                o_door_open_cmd,
  output logic                o_door_close_cmd,
  output logic                o_door_closed,
  output logic                o_up_clr,
  output logic                o_dn_clr,
  output logic                o_flr_clr,
  output logic [1:0]          o_state
);

  localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(CLOSE_CYCLES - 1);

  door_state_t      state_reg, state_next;
  logic             load, en, done, clr;
  logic [CNT_W-1:0] load_val;
  logic             at_flr, serve, keep_open;

  assign at_flr    = |i_flr_pos;
  assign serve     = ~i_motion & at_flr & (i_has_rqst_at_stopped_flr | i_open_btn);
  assign keep_open = i_door_obstruct | i_open_btn;

  lift_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .done     (done)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_val   = '0;
    en         = 1'b0;
    clr        = 1'b0;
    case (state_reg)
      ST_CLOSED: begin
        if (serve) begin
          state_next = ST_OPENING;
          load       = 1'b1;
          load_val   = OPEN_LOAD;
          clr        = 1'b1;
        end
      end
      ST_OPENING: begin
        if (done) begin
          state_next = ST_OPEN_HOLD;
          load       = 1'b1;
          load_val   = HOLD_LOAD;
        end else begin
          en = 1'b1;
        end
      end
      ST_OPEN_HOLD: begin
        // Anything that keeps the door open outranks the close button.
        if (keep_open | i_has_rqst_at_stopped_flr) begin
          load     = 1'b1;
          load_val = HOLD_LOAD;
          clr      = i_has_rqst_at_stopped_flr;
        end else if (i_close_btn || done) begin
          state_next = ST_CLOSING;
          load       = 1'b1;
          load_val   = CLOSE_LOAD;
        end else begin
          en = 1'b1;
        end
      end
      ST_CLOSING: begin
        if (keep_open) begin
          state_next = ST_OPENING;
          load       = 1'b1;
          load_val   = OPEN_LOAD;
        end else if (done) begin
          state_next = ST_CLOSED;
        end else begin
          en = 1'b1;
        end
      end
      default: state_next = ST_CLOSED;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_CLOSED;
      o_motion_enable  <= 1'b1;
      o_door_closed    <= 1'b1;
      o_door_open_cmd  <= 1'b0;
      o_door_close_cmd <= 1'b0;
      o_up_clr         <= 1'b0;
      o_dn_clr         <= 1'b0;
      o_flr_clr        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      o_motion_enable  <= (state_next == ST_CLOSED);
      o_door_closed    <= (state_next == ST_CLOSED);
      o_door_open_cmd  <= (state_next == ST_OPENING) || (state_next == ST_OPEN_HOLD);
      o_door_close_cmd <= (state_next == ST_CLOSING);
      o_up_clr         <= clr & (i_direction == DIR_UP);
      o_dn_clr         <= clr & (i_direction == DIR_DN);
      o_flr_clr        <= clr;
    end
  end

  assign o_state = state_reg;

endmodule
